// File: rtl/visor_av_pkg.sv
// Shared definitions for the Avalon-MM write slave.
//   av_state_e : handshake FSM states (IDLE, WAIT, GRANT)
//   AV_ADDR_W / AV_DATA_W : Avalon address and data widths
//   AV_REC_W   : width of one write record {addr, data}
package visor_av_pkg;

  localparam int AV_ADDR_W = 16;
  localparam int AV_DATA_W = 16;
  localparam int AV_REC_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } av_state_e;

endpackage

// File: rtl/av_evt_fifo.sv
// Synchronous show-ahead FIFO for write records.
//   clk, rst_n   : clock, asynchronous active-low reset (pointers and level)
//   push, din    : write a record (ignored when full)
//   pop          : drop the head record (ignored when empty)
//   dout         : head record, valid whenever empty=0
//   level        : occupancy 0..DEPTH
//   full, empty  : occupancy flags
module av_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q,  level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH is implicit.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; its content is qualified by level.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/av_write_slave.sv
// Avalon-MM write-only slave with programmable wait states.
//   sysclk, sysreset_n        : clock, asynchronous active-low reset
//   av_address/av_writedata   : Avalon write address and data
//   av_write, av_waitrequest  : Avalon request and stall
//   evt_valid/evt_ready       : show-ahead record stream (head of FIFO)
//   evt_addr/evt_data         : head record fields
//   rd_sel, rd_data           : combinational shadow register read port
//   fifo_level                : record FIFO occupancy
//   wr_count                  : accepted-write counter (wraps)
module av_write_slave
  import visor_av_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int NUM_SHADOW  = 8
) (
  input  logic                          sysclk,
  input  logic                          sysreset_n,
  input  logic [15:0]                   av_address,
  input  logic [15:0]                   av_writedata,
  input  logic                          av_write,
  output logic                          av_waitrequest,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [15:0]                   evt_addr,
  output logic [15:0]                   evt_data,
  input  logic [$clog2(NUM_SHADOW)-1:0] rd_sel,
  output logic [15:0]                   rd_data,
  output logic [4:0]                    fifo_level,
  output logic [15:0]                   wr_count
);

  localparam int          SEL_W    = $clog2(NUM_SHADOW);
  localparam int          LW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] SHADOW_N = 16'(NUM_SHADOW);

  av_state_e             state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [15:0]           wr_count_q, wr_count_d;
  logic [15:0]           shadow_q [NUM_SHADOW];
  logic [15:0]           shadow_d [NUM_SHADOW];
  logic                  accept;
  logic                  fifo_full, fifo_empty;
  logic [LW-1:0]         fifo_lvl;
  logic [AV_REC_W-1:0]   fifo_dout;

  // Handshake FSM: IDLE -> WAIT (count down) -> GRANT (accept cycle).
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (av_write) begin
          state_d = WAIT;
          wcnt_d  = 4'(WAIT_STATES);
        end
      end
      WAIT: begin
        if (!av_write) begin
          state_d = IDLE;
        end else if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else if (!fifo_full) begin
          // Only a not-full FIFO may be granted; a pop cannot refill it,
          // so the push in GRANT always finds room.
          state_d = GRANT;
        end
      end
      GRANT: begin
        state_d = IDLE;
        accept  = av_write;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter and shadow bank update on the accept edge.
  always_comb begin
    wr_count_d = wr_count_q;
    shadow_d   = shadow_q;
    if (accept) begin
      wr_count_d = wr_count_q + 16'd1;
      if (av_address < SHADOW_N) begin
        shadow_d[av_address[SEL_W-1:0]] = av_writedata;
      end
    end
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q    <= IDLE;
      wcnt_q     <= 4'd0;
      wr_count_q <= 16'd0;
      for (int i = 0; i < NUM_SHADOW; i++) shadow_q[i] <= 16'd0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      wr_count_q <= wr_count_d;
      shadow_q   <= shadow_d;
    end
  end

  av_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AV_REC_W)
  ) u_fifo (
    .clk   (sysclk),
    .rst_n (sysreset_n),
    .push  (accept),
    .pop   (evt_valid && evt_ready),
    .din   ({av_address, av_writedata}),
    .dout  (fifo_dout),
    .level (fifo_lvl),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign av_waitrequest       = av_write && (state_q != GRANT);
  assign evt_valid            = !fifo_empty;
  assign {evt_addr, evt_data} = fifo_dout;
  assign rd_data              = shadow_q[rd_sel];
  assign fifo_level           = 5'(fifo_lvl);
  assign wr_count             = wr_count_q;

endmodule

// File: tb/tb_av_write_slave.sv
// Self-checking bench for av_write_slave (default parameters).
module tb_av_write_slave;

  localparam int W     = 1;
  localparam int DEPTH = 4;
  localparam int NSH   = 8;

  logic        sysclk = 1'b0;
  logic        sysreset_n;
  logic [15:0] av_address, av_writedata;
  logic        av_write;
  logic        av_waitrequest;
  logic        evt_valid, evt_ready;
  logic [15:0] evt_addr, evt_data;
  logic [2:0]  rd_sel;
  logic [15:0] rd_data;
  logic [4:0]  fifo_level;
  logic [15:0] wr_count;

  int total = 0;
  int bad   = 0;

  // Reference model: record queue, shadow image, write count.
  logic [31:0] q_m [$];
  logic [15:0] shadow_m [NSH];
  logic [15:0] cnt_m;

  always #5 sysclk = ~sysclk;

  av_write_slave #(
    .WAIT_STATES (W),
    .FIFO_DEPTH  (DEPTH),
    .NUM_SHADOW  (NSH)
  ) dut (
    .sysclk         (sysclk),
    .sysreset_n     (sysreset_n),
    .av_address     (av_address),
    .av_writedata   (av_writedata),
    .av_write       (av_write),
    .av_waitrequest (av_waitrequest),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_addr       (evt_addr),
    .evt_data       (evt_data),
    .rd_sel         (rd_sel),
    .rd_data        (rd_data),
    .fifo_level     (fifo_level),
    .wr_count       (wr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    cnt_m = 16'd0;
    for (int i = 0; i < NSH; i++) shadow_m[i] = 16'd0;
  endtask

  task automatic model_accept(input logic [15:0] a, input logic [15:0] d);
    q_m.push_back({a, d});
    cnt_m = cnt_m + 16'd1;
    if (a < NSH) shadow_m[a] = d;
  endtask

  // Called at posedge+1 with av_write already high. Counts stalled cycles
  // until waitrequest drops, then steps over the accept edge.
  task automatic wait_accept(input string tag, input int exp_lat, output bit ok);
    int  cyc;
    bit  done;
    cyc  = 0;
    done = 1'b0;
    ok   = 1'b0;
    while (!done) begin
      @(negedge sysclk);
      if (!av_waitrequest) begin
        done = 1'b1;
        ok   = 1'b1;
      end else begin
        cyc++;
        if (cyc > 100) begin
          chk({tag, "_timeout"}, 32'(cyc), 32'(exp_lat));
          done = 1'b1;
        end
        @(posedge sysclk); #1;
      end
    end
    if (ok && exp_lat >= 0) chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    if (ok) begin
      @(posedge sysclk); #1;
    end
  endtask

  task automatic post_checks(input string tag);
    chk({tag, "_wr_count"}, 32'(wr_count), 32'(cnt_m));
    chk({tag, "_level"}, 32'(fifo_level), 32'(q_m.size()));
    chk({tag, "_valid"}, 32'(evt_valid), 32'(q_m.size() != 0));
    if (q_m.size() != 0) chk({tag, "_head"}, {evt_addr, evt_data}, q_m[0]);
  endtask

  task automatic do_write(input string tag, input logic [15:0] a, input logic [15:0] d);
    bit ok;
    int exp_lat;
    exp_lat      = (q_m.size() < DEPTH) ? W + 2 : -1;
    av_address   = a;
    av_writedata = d;
    av_write     = 1'b1;
    wait_accept(tag, exp_lat, ok);
    av_write = 1'b0;
    if (ok) model_accept(a, d);
    post_checks(tag);
  endtask

  task automatic pop_check(input string tag);
    chk({tag, "_pop_valid"}, 32'(evt_valid), 32'd1);
    if (q_m.size() != 0) chk({tag, "_pop_rec"}, {evt_addr, evt_data}, q_m[0]);
    evt_ready = 1'b1;
    @(posedge sysclk); #1;
    evt_ready = 1'b0;
    if (q_m.size() != 0) void'(q_m.pop_front());
    chk({tag, "_pop_level"}, 32'(fifo_level), 32'(q_m.size()));
  endtask

  task automatic check_shadow(input string tag);
    for (int s = 0; s < NSH; s++) begin
      rd_sel = 3'(s);
      #0.5;
      chk({tag, "_shadow"}, 32'(rd_data), 32'(shadow_m[s]));
    end
    @(posedge sysclk); #1;
  endtask

  initial begin
    bit          ok;
    logic [15:0] a, d;

    sysreset_n   = 1'b0;
    av_address   = 16'd0;
    av_writedata = 16'd0;
    av_write     = 1'b0;
    evt_ready    = 1'b0;
    rd_sel       = 3'd0;
    model_reset();

    // Reset values
    repeat (2) @(posedge sysclk);
    #1;
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_waitreq_lo", 32'(av_waitrequest), 32'd0);
    av_write = 1'b1;
    #1;
    chk("rst_waitreq_hi", 32'(av_waitrequest), 32'd1);
    av_write = 1'b0;
    @(posedge sysclk); #1;
    sysreset_n = 1'b1;
    @(posedge sysclk); #1;

    // Basic write: addr 3 / 0xBEEF
    do_write("basic", 16'h0003, 16'hBEEF);
    rd_sel = 3'd3;
    #1;
    chk("basic_rd3", 32'(rd_data), 32'h0000BEEF);
    pop_check("basic");

    // evt_ready while empty is ignored
    evt_ready = 1'b1;
    repeat (2) @(posedge sysclk);
    #1;
    evt_ready = 1'b0;
    chk("empty_pop_level", 32'(fifo_level), 32'd0);
    chk("empty_pop_valid", 32'(evt_valid), 32'd0);

    // Full FIFO: four writes fill it, the fifth stalls until one pop
    for (int i = 1; i <= 4; i++) do_write("fill", 16'h0010 + 16'(i), 16'hA000 + 16'(i));
    av_address   = 16'h0015;
    av_writedata = 16'hA005;
    av_write     = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge sysclk);
      chk("full_stall_wreq", 32'(av_waitrequest), 32'd1);
      chk("full_stall_level", 32'(fifo_level), 32'd4);
      @(posedge sysclk); #1;
    end
    pop_check("full");
    wait_accept("full_resume", 1, ok);
    av_write = 1'b0;
    if (ok) model_accept(16'h0015, 16'hA005);
    post_checks("full_resume");
    while (q_m.size() != 0) pop_check("order");

    // Out-of-range address: FIFO only, shadow untouched
    do_write("oob", 16'h0100, 16'h1234);
    check_shadow("oob");
    pop_check("oob");

    // Abandoned request after one cycle
    av_address   = 16'h0002;
    av_writedata = 16'h5555;
    av_write     = 1'b1;
    @(negedge sysclk);
    chk("abandon_wreq", 32'(av_waitrequest), 32'd1);
    @(posedge sysclk); #1;
    av_write = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    post_checks("abandon");
    check_shadow("abandon");
    // A fresh write after the abandon sees the full IDLE latency
    do_write("after_abandon", 16'h0001, 16'h7777);
    pop_check("after_abandon");

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      if (q_m.size() != 0 && ($urandom_range(0, 3) == 0 || q_m.size() == DEPTH)) pop_check("rnd");
      a = $urandom_range(0, 1) ? 16'($urandom_range(0, NSH - 1)) : 16'($urandom);
      d = 16'($urandom);
      do_write("rnd", a, d);
    end
    check_shadow("rnd");
    while (q_m.size() != 0) pop_check("rnd_drain");

    // wr_count wrap
    force dut.wr_count_q = 16'hFFFF;
    @(posedge sysclk); #1;
    release dut.wr_count_q;
    cnt_m = 16'hFFFF;
    chk("wrap_preload", 32'(wr_count), 32'h0000FFFF);
    do_write("wrap", 16'h0004, 16'h4444);
    chk("wrap_zero", 32'(wr_count), 32'd0);
    pop_check("wrap");

    // Reset mid-transfer with two records queued
    do_write("pre_rst", 16'h0005, 16'h0505);
    do_write("pre_rst", 16'h0006, 16'h0606);
    av_address   = 16'h0007;
    av_writedata = 16'h0707;
    av_write     = 1'b1;
    @(posedge sysclk); #1;
    sysreset_n = 1'b0;
    rd_sel     = 3'd5;
    #1;
    model_reset();
    chk("midrst_valid", 32'(evt_valid), 32'd0);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    chk("midrst_wr_count", 32'(wr_count), 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    chk("midrst_wreq", 32'(av_waitrequest), 32'd1);
    @(posedge sysclk); #1;
    sysreset_n = 1'b1;
    wait_accept("post_rst", W + 2, ok);
    av_write = 1'b0;
    if (ok) model_accept(16'h0007, 16'h0707);
    post_checks("post_rst");
    check_shadow("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
